// File: rtl/riscv_pkg.sv
// Shared decode constants and types for the integer pipeline.
// Holds the ALU control codes, the alu_op encoding, funct3 values and the ID/EX register layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b1111;
  localparam logic [3:0] ALU_SRL = 4'b1110;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_RTYPE = 2'b10,
    ALU_OP_ITYPE = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // All-zero value of this struct is the bubble.
  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
  } idex_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: (alu_op, funct3, funct7b5) -> (ctrl, illegal).
module alu_ctrl_dec
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_OP_ADD: ctrl = ALU_ADD;
      ALU_OP_SUB: ctrl = ALU_SUB;
      default: begin
        case (funct3)
          // funct7b5 only selects SUB for register-register ops; for I-type it is immediate data.
          F3_ADD:  ctrl = (alu_op_e'(alu_op) == ALU_OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_AND:  ctrl = ALU_AND;
          F3_OR:   ctrl = ALU_OR;
          F3_XOR:  ctrl = ALU_XOR;
          F3_SRL:  ctrl = ALU_SRL;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX/MEM and MEM/WB forwarding,
// and load-use hazard detection.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [31:0]     id_pc,
  input  logic [31:0]     id_rs1_data,
  input  logic [31:0]     id_rs2_data,
  input  logic [31:0]     id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [31:0]     exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [31:0]     memwb_result,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic            ex_alu_en,
  output logic            ex_illegal,
  output logic [3:0]      ex_alu_ctrl,
  output logic [31:0]     ex_in1,
  output logic [31:0]     ex_in2,
  output logic [31:0]     ex_store_data,
  output logic [31:0]     ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write
);

  idex_t           ex_q;
  logic [3:0]      dec_ctrl;
  logic            dec_illegal;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  alu_ctrl_dec u_dec (
    .alu_op   (id_alu_op),
    .funct3   (id_funct3),
    .funct7b5 (id_funct7b5),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal)
  );

  // Upstream holds PC and IF/ID while this is high; flush still takes priority there.
  assign load_use_stall = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                          ((id_rs1 == ex_q.rd) | (id_rs2 == ex_q.rd));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_q <= '0;
    end else if (stall) begin
      ex_q <= ex_q;
    end else if (load_use_stall || !id_valid) begin
      ex_q <= '0;
    end else begin
      ex_q.valid     <= 1'b1;
      ex_q.illegal   <= dec_illegal;
      ex_q.alu_ctrl  <= dec_ctrl;
      ex_q.pc        <= id_pc;
      ex_q.rd        <= id_rd;
      ex_q.rs1       <= id_rs1;
      ex_q.rs2       <= id_rs2;
      ex_q.rs1_data  <= id_rs1_data;
      ex_q.rs2_data  <= id_rs2_data;
      ex_q.imm       <= id_imm;
      ex_q.alu_src   <= id_alu_src;
      ex_q.mem_read  <= id_mem_read;
      ex_q.mem_write <= id_mem_write;
      ex_q.reg_write <= id_reg_write & ~dec_illegal;
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_q.rs1)
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_q.rs1)
      fwd_rs1 = memwb_result;

    fwd_rs2 = ex_q.rs2_data;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == ex_q.rs2)
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == ex_q.rs2)
      fwd_rs2 = memwb_result;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_illegal    = ex_q.illegal;
  assign ex_alu_en     = ex_q.valid & ~ex_q.illegal;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_in1        = ex_q.valid ? fwd_rs1 : '0;
  assign ex_in2        = ex_q.valid ? (ex_q.alu_src ? ex_q.imm : fwd_rs2) : '0;
  assign ex_store_data = ex_q.valid ? fwd_rs2 : '0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage with hand-computed expected values.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        load_use_stall, ex_valid, ex_alu_en, ex_illegal;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_in1, ex_in2, ex_store_data, ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_alu_en(ex_alu_en),
    .ex_illegal(ex_illegal), .ex_alu_ctrl(ex_alu_ctrl), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one decoded instruction on the ID inputs
  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [1:0] op,
                          input logic [2:0] f3, input logic f7, input logic src,
                          input logic mr, input logic mw, input logic rw);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2;
    id_rs2_data = d2; id_rd = rd; id_imm = imm; id_alu_op = op; id_funct3 = f3;
    id_funct7b5 = f7; id_alu_src = src; id_mem_read = mr; id_mem_write = mw;
    id_reg_write = rw;
  endtask

  task automatic drive_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write = erw; exmem_rd = erd; exmem_result = eres;
    memwb_reg_write = mrw; memwb_rd = mrd; memwb_result = mres;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 32'(ex_valid), 32'd0);
    check({tag, ".alu_en"}, 32'(ex_alu_en), 32'd0);
    check({tag, ".illegal"}, 32'(ex_illegal), 32'd0);
    check({tag, ".ctrl"}, 32'(ex_alu_ctrl), 32'd0);
    check({tag, ".in1"}, ex_in1, 32'd0);
    check({tag, ".in2"}, ex_in2, 32'd0);
    check({tag, ".sdata"}, ex_store_data, 32'd0);
    check({tag, ".pc"}, ex_pc, 32'd0);
    check({tag, ".rd"}, 32'(ex_rd), 32'd0);
    check({tag, ".mr_mw_rw"}, 32'({ex_mem_read, ex_mem_write, ex_reg_write}), 32'd0);
    check({tag, ".lus"}, 32'(load_use_stall), 32'd0);
  endtask

  // decode table: alu_op, funct3, funct7b5 -> ctrl, illegal
  typedef struct {
    logic [1:0] op; logic [2:0] f3; logic f7; logic [3:0] ctrl; logic ill;
  } dec_vec_t;
  dec_vec_t dec_tbl[9] = '{
    '{2'b00, 3'b111, 1'b1, 4'b0010, 1'b0},
    '{2'b01, 3'b000, 1'b0, 4'b0110, 1'b0},
    '{2'b10, 3'b111, 1'b0, 4'b0000, 1'b0},
    '{2'b10, 3'b110, 1'b0, 4'b0001, 1'b0},
    '{2'b11, 3'b100, 1'b0, 4'b1111, 1'b0},
    '{2'b10, 3'b101, 1'b1, 4'b1110, 1'b0},
    '{2'b11, 3'b000, 1'b1, 4'b0010, 1'b0},
    '{2'b11, 3'b010, 1'b0, 4'b0010, 1'b1},
    '{2'b10, 3'b011, 1'b0, 4'b0010, 1'b1}
  };

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
    drive_fwd(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // add x3,x1,x2
    drive_id(1, 32'h10, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 2'b10, 3'b000, 0, 0, 0, 0, 1);
    tick();
    check("add.valid", 32'(ex_valid), 32'd1);
    check("add.ctrl", 32'(ex_alu_ctrl), 32'h2);
    check("add.in1", ex_in1, 32'd5);
    check("add.in2", ex_in2, 32'd7);
    check("add.en", 32'(ex_alu_en), 32'd1);
    check("add.rd", 32'(ex_rd), 32'd3);
    check("add.pc", ex_pc, 32'h10);
    check("add.rw", 32'(ex_reg_write), 32'd1);

    // sub
    @(negedge clk);
    id_funct7b5 = 1'b1;
    tick();
    check("sub.ctrl", 32'(ex_alu_ctrl), 32'h6);

    // decode table
    foreach (dec_tbl[i]) begin
      @(negedge clk);
      drive_id(1, 32'h20, 5'd1, 32'd1, 5'd2, 32'd2, 5'd6, 32'd0, dec_tbl[i].op,
               dec_tbl[i].f3, dec_tbl[i].f7, 0, 0, 0, 1);
      tick();
      check($sformatf("dec%0d.ctrl", i), 32'(ex_alu_ctrl), 32'(dec_tbl[i].ctrl));
      check($sformatf("dec%0d.ill", i), 32'(ex_illegal), 32'(dec_tbl[i].ill));
      check($sformatf("dec%0d.en", i), 32'(ex_alu_en), 32'(!dec_tbl[i].ill));
      check($sformatf("dec%0d.rw", i), 32'(ex_reg_write), 32'(!dec_tbl[i].ill));
    end

    // forwarding priority
    @(negedge clk);
    drive_id(1, 32'h30, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 2'b10, 3'b000, 0, 0, 0, 0, 1);
    drive_fwd(1, 5'd1, 32'hAA, 1, 5'd1, 32'hBB);
    tick();
    check("fwd.exmem", ex_in1, 32'hAA);
    check("fwd.rs2_none", ex_in2, 32'd7);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd.memwb", ex_in1, 32'hBB);
    drive_fwd(1, 5'd2, 32'hCC, 0, 5'd0, 32'd0);
    #1;
    check("fwd.rs2_exmem", ex_in2, 32'hCC);
    check("fwd.sdata", ex_store_data, 32'hCC);
    check("fwd.rs1_reg", ex_in1, 32'd5);
    @(negedge clk);
    drive_id(1, 32'h34, 5'd0, 32'h11, 5'd2, 32'd7, 5'd3, 32'd0, 2'b10, 3'b000, 0, 0, 0, 0, 1);
    drive_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
    tick();
    check("fwd.x0", ex_in1, 32'h11);

    // load-use
    @(negedge clk);
    drive_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 32'h40, 5'd1, 32'h100, 5'd0, 32'd0, 5'd4, 32'd8, 2'b00, 3'b010, 0, 1, 1, 0, 1);
    tick();
    check("lw.mr", 32'(ex_mem_read), 32'd1);
    check("lw.in1", ex_in1, 32'h100);
    check("lw.in2", ex_in2, 32'd8);
    check("lw.ctrl", 32'(ex_alu_ctrl), 32'h2);
    @(negedge clk);
    drive_id(1, 32'h44, 5'd4, 32'd0, 5'd2, 32'd7, 5'd5, 32'd0, 2'b10, 3'b000, 0, 0, 0, 0, 1);
    #1;
    check("lu.stall", 32'(load_use_stall), 32'd1);
    tick();
    check("lu.bubble", 32'(ex_valid), 32'd0);
    check("lu.bubble_en", 32'(ex_alu_en), 32'd0);
    check("lu.bubble_rw", 32'(ex_reg_write), 32'd0);
    check("lu.released", 32'(load_use_stall), 32'd0);
    @(negedge clk);
    drive_fwd(0, 0, 0, 1, 5'd4, 32'h1234);
    tick();
    check("lu.valid", 32'(ex_valid), 32'd1);
    check("lu.fwd", ex_in1, 32'h1234);
    check("lu.in2", ex_in2, 32'd7);
    check("lu.rd", 32'(ex_rd), 32'd5);

    // flush with stall
    @(negedge clk);
    drive_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 32'h48, 5'd1, 32'd1, 5'd2, 32'd2, 5'd6, 32'd0, 2'b10, 3'b000, 0, 0, 0, 0, 1);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush.valid", 32'(ex_valid), 32'd0);
    check("flush.rw", 32'(ex_reg_write), 32'd0);
    check("flush.in1", ex_in1, 32'd0);

    // stall holds for 3 cycles
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    drive_id(1, 32'h50, 5'd1, 32'd3, 5'd2, 32'd9, 5'd7, 32'd0, 2'b10, 3'b100, 0, 0, 0, 0, 1);
    tick();
    check("xor.ctrl", 32'(ex_alu_ctrl), 32'hF);
    @(negedge clk);
    stall = 1'b1;
    drive_id(1, 32'h80, 5'd8, 32'd55, 5'd9, 32'd66, 5'd9, 32'd0, 2'b10, 3'b111, 0, 0, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d.ctrl", c), 32'(ex_alu_ctrl), 32'hF);
      check($sformatf("stall%0d.pc", c), ex_pc, 32'h50);
      check($sformatf("stall%0d.rd", c), 32'(ex_rd), 32'd7);
      check($sformatf("stall%0d.in1", c), ex_in1, 32'd3);
      check($sformatf("stall%0d.in2", c), ex_in2, 32'd9);
    end
    @(negedge clk);
    stall = 1'b0;

    // addi with imm = -1
    drive_id(1, 32'h60, 5'd1, 32'd10, 5'd0, 32'd0, 5'd3, 32'hFFFF_FFFF, 2'b11, 3'b000, 1, 1, 0, 0, 1);
    tick();
    check("addi.in2", ex_in2, 32'hFFFF_FFFF);
    check("addi.in1", ex_in1, 32'd10);
    check("addi.ctrl", 32'(ex_alu_ctrl), 32'h2);

    // invalid decode slot loads a bubble
    @(negedge clk);
    id_valid = 1'b0;
    tick();
    check("idinv.valid", 32'(ex_valid), 32'd0);
    check("idinv.rw", 32'(ex_reg_write), 32'd0);

    // reset mid-stream with a pending load-use stall
    @(negedge clk);
    drive_id(1, 32'h70, 5'd1, 32'h200, 5'd0, 32'd0, 5'd4, 32'd0, 2'b00, 3'b010, 0, 1, 1, 0, 1);
    tick();
    @(negedge clk);
    drive_id(1, 32'h74, 5'd4, 32'd0, 5'd0, 32'd0, 5'd5, 32'd0, 2'b10, 3'b000, 0, 0, 0, 0, 1);
    stall = 1'b1;
    #1;
    check("rst.pre_lus", 32'(load_use_stall), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU. Each cycle it registers one decoded instruction and derives the ALU control code and enable from funct3/funct7/alu_op. It applies EX/MEM and MEM/WB operand forwarding and presents `en`/`in1`/`in2`/`ctrl`-ready operands to the ALU. It also detects load-use hazards and handles pipeline stall/flush.

## Interface
- XLEN, 32, datapath width (ALU is 32-bit; only 32 is supported)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  external hold (e.g. memory busy)
- flush  in  1  kill the instruction entering EX (branch taken)
- id_valid  in  1  decode slot holds an instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN  decode operands
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct3  in  3, id_funct7b5  in  1  instruction fields
- id_alu_op  in  2  00 add (ld/st), 01 sub (branch), 10 R-type, 11 I-type arith
- id_alu_src, id_mem_read, id_mem_write, id_reg_write  in  1  control bits
- exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  XLEN  forwarding source 1
- memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  XLEN  forwarding source 2
- load_use_stall  out  1  combinational; upstream must hold PC and IF/ID
- ex_valid, ex_alu_en, ex_illegal  out  1
- ex_alu_ctrl  out  4  ALU ctrl code
- ex_in1, ex_in2, ex_store_data  out  XLEN  ALU operands; forwarded rs2 for stores
- ex_pc  out  XLEN, ex_rd  out  5
- ex_mem_read, ex_mem_write, ex_reg_write  out  1

## Operation
- ALU ctrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, XOR 1111, SHIFT-R 1110.
- Decode by alu_op:
  - 00 → ADD; 01 → SUB.
  - 10/11 by funct3: 000 → ADD, or SUB only when alu_op=10 and funct7b5=1; 111 → AND; 110 → OR; 100 → XOR; 101 → 1110.
  - funct3 001/010/011 → ex_illegal=1, ex_alu_en=0, ex_reg_write=0, ctrl=0010.
- ex_alu_en = ex_valid & ~ex_illegal.
- Forwarding for rs1 and rs2 independently:
  - EX/MEM is chosen if exmem_reg_write and exmem_rd==rs≠0.
  - Otherwise MEM/WB is chosen if memwb_reg_write and memwb_rd==rs≠0.
  - Otherwise the registered operand is used.
  - Index 0 is never forwarded.
- ex_in1 = fwd rs1; ex_in2 = ex_alu_src ? imm : fwd rs2; ex_store_data = fwd rs2.
- When ex_valid=0, ex_in1, ex_in2 and ex_store_data are driven to 0.
- load_use_stall = id_valid & ex_valid & ex_mem_read & ex_rd≠0 & (id_rs1==ex_rd | id_rs2==ex_rd).
- Register update priority per edge:
  - rst → all registers 0.
  - flush → bubble.
  - stall → hold.
  - load_use_stall → bubble.
  - Otherwise load id_*.
- Bubble: ex_valid=0 and all control bits 0.
- An instruction with id_valid=0 loads as a bubble.

## Timing
- Latency: 1 cycle, ID inputs to registered ex_* outputs.
- Forwarding muxes and load_use_stall are combinational, with no added cycle.
- Reset values: ex_valid, ex_alu_en, ex_illegal, ex_mem_read, ex_mem_write, ex_reg_write = 0; ex_alu_ctrl=0000; ex_rd=0; ex_pc=0; ex_in1, ex_in2, ex_store_data = 0.
- load_use_stall is 0 during and after reset.
- Flush together with stall: flush wins, and EX becomes a bubble.
- Flush together with load_use_stall: bubble. Upstream must honour flush over the hold.
- Stall held N cycles: EX contents are frozen. Forwarded operand values may change if EX/MEM or MEM/WB change.
- Reset mid-stall: bubble on the next edge; no stale instruction survives.

## Structure
- Shared package riscv_pkg holds:
  - ALU ctrl localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SRL).
  - alu_op enum.
  - The funct3 constants.
- One combinational sub-module, alu_ctrl_dec, maps (alu_op, funct3, funct7b5) to (ctrl, illegal).
- Forwarding muxes and hazard compare stay inline.

## Test plan
- add x3,x1,x2 (rs1=5, rs2=7) → one cycle later ex_alu_ctrl=0010, ex_in1=5, ex_in2=7, ex_alu_en=1; R-type funct3=000, funct7b5=1 → ctrl 0110.
- exmem writes x1=0xAA and memwb writes x1=0xBB, then an instruction reads x1 → ex_in1=0xAA; with exmem_rd=0 and reg_write=1 → no forward.
- lw x4 in EX, next instruction reads x4 → load_use_stall=1, EX gets a bubble (ex_valid=0); next cycle the instruction enters with x4 forwarded from MEM/WB.
- flush=1 and stall=1 in the same cycle → ex_valid=0 next cycle; stall alone 3 cycles → ex_* unchanged.
- funct3=001, alu_op=10 → ex_illegal=1, ex_alu_en=0, ex_reg_write=0; ADDI imm=-1 with rs1=1 → ex_in2=0xFFFFFFFF, ctrl 0010.
- rst asserted mid-stream → all ex_* outputs 0 on the next edge and load_use_stall=0.
